imem_loader: RTL and testbench

//  Writer end of the instruction-memory interface: the processor only reads imem; this block fills it.

---
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader that fills instruction memory with big-endian words and
// keeps the CPU in reset until the image has been written and its XOR checksum matches.
module imem_loader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int CPU_RST_HOLD = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_in_valid,
  input  logic [7:0]            i_in_byte,
  output logic                  o_in_ready,
  output logic                  o_imem_wEn,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_dataIn,
  output logic                  o_cpu_reset,
  output logic                  o_done,
  output logic                  o_error
);

  localparam logic [2:0] S_HDR_HI = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  // One extra index bit so a full 2**ADDR_WIDTH image can still reach its terminal count.
  localparam int              IW        = ADDR_WIDTH + 1;
  localparam int              HW        = (CPU_RST_HOLD > 1) ? $clog2(CPU_RST_HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(CPU_RST_HOLD - 1);
  localparam logic [31:0]     MAX_WORDS = 32'd1 << ADDR_WIDTH;

  logic [2:0]            r_state;
  logic [15:0]           r_cnt;
  logic [IW-1:0]         r_idx;
  logic [7:0]            r_sum;
  logic [23:0]           r_word;
  logic [1:0]            r_nbyte;
  logic [HW-1:0]         r_hold;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;

  logic                  w_xfer;
  logic [15:0]           w_count;
  logic [IW-1:0]         w_idx_next;

  assign o_in_ready = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) ||
                      (r_state == S_DATA)   || (r_state == S_CHK);
  assign w_xfer     = i_in_valid & o_in_ready;
  assign w_count    = {r_cnt[15:8], i_in_byte};
  assign w_idx_next = r_idx + IW'(1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_HDR_HI;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_word  <= '0;
      r_nbyte <= '0;
      r_hold  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_HDR_HI: begin
          if (w_xfer) begin
            r_cnt[15:8] <= i_in_byte;
            r_state     <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (w_xfer) begin
            r_cnt[7:0] <= i_in_byte;
            if ({16'd0, w_count} > MAX_WORDS) r_state <= S_ERR;
            else if (w_count == 16'd0)        r_state <= S_CHK;
            else                              r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_sum   <= r_sum ^ i_in_byte;
            r_word  <= {r_word[15:0], i_in_byte};
            r_nbyte <= r_nbyte + 2'd1;
            // Latch the write port on the 4th byte so it holds steady after the strobe.
            if (r_nbyte == 2'd3) begin
              r_addr  <= r_idx[ADDR_WIDTH-1:0];
              r_data  <= {r_word, i_in_byte};
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_idx   <= w_idx_next;
          r_state <= (32'(w_idx_next) == 32'(r_cnt)) ? S_CHK : S_DATA;
        end
        S_CHK: begin
          if (w_xfer) begin
            r_hold  <= '0;
            r_state <= (i_in_byte == r_sum) ? S_HOLD : S_ERR;
          end
        end
        S_HOLD: begin
          if (r_hold == HOLD_LAST) r_state <= S_DONE;
          else                     r_hold  <= r_hold + HW'(1);
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign o_imem_wEn    = (r_state == S_WRITE);
  assign o_imem_addr   = r_addr;
  assign o_imem_dataIn = r_data;
  assign o_cpu_reset   = (r_state != S_DONE);
  assign o_done        = (r_state == S_DONE);
  assign o_error       = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized byte streams compared against
// an image-level model of the expected imem writes and final load outcome.
module tb_imem_loader;
  localparam int AW   = 12;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [7:0]    byt = 8'h00;
  logic          rdy, wen, cpu_rst, done, err;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;

  imem_loader #(.ADDR_WIDTH(AW), .CPU_RST_HOLD(HOLD)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_in_valid   (vld),
    .i_in_byte    (byt),
    .o_in_ready   (rdy),
    .o_imem_wEn   (wen),
    .o_imem_addr  (addr),
    .o_imem_dataIn(wdata),
    .o_cpu_reset  (cpu_rst),
    .o_done       (done),
    .o_error      (err)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [7:0]  stim[$];
  logic [63:0] exp_wr[$];
  logic [63:0] got_wr[$];
  int          bad_rdy = 0;
  int          bad_lat = 0;
  logic        acc_prev = 1'b0;

  // Inputs change just after posedge, so negedge sees stable values on both sides.
  always @(negedge clk) begin
    if (wen) begin
      got_wr.push_back({32'(addr), wdata});
      if (rdy) bad_rdy <= bad_rdy + 1;
      if (!acc_prev) bad_lat <= bad_lat + 1;
    end
    acc_prev <= vld & rdy;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check(tag, {rdy, wen, 12'(addr), wdata, cpu_rst, done, err},
          {1'b1, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    ok = 1'b0;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      repeat ($urandom_range(1, 3)) begin
        vld = 1'b0;
        @(posedge clk); #1;
      end
    end
    vld = 1'b1;
    byt = b;
    for (int w = 0; w < 64 && !ok; w++) begin
      @(negedge clk);
      ok = rdy;
      @(posedge clk); #1;
    end
  endtask

  // Image-level model: header count, big-endian words at consecutive addresses, XOR of data bytes.
  task automatic model(output bit ok, output int ncons);
    int          n;
    logic [7:0]  s;
    logic [31:0] w;
    exp_wr.delete();
    n = int'({stim[0], stim[1]});
    s = 8'h00;
    if (n > (1 << AW)) begin
      ok    = 1'b0;
      ncons = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = {stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]};
      exp_wr.push_back({32'(k), w});
      s = s ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    ncons = 3 + 4 * n;
    ok    = (stim[2+4*n] == s);
  endtask

  task automatic build(input int n, input bit good);
    logic [7:0] s;
    logic [7:0] d;
    stim.delete();
    stim.push_back(n[15:8]);
    stim.push_back(n[7:0]);
    s = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      d = 8'($urandom);
      stim.push_back(d);
      s = s ^ d;
    end
    if (!good) s = s ^ 8'($urandom_range(1, 255));
    stim.push_back(s);
  endtask

  task automatic run_load(input string name, input bit gaps);
    bit ok_exp;
    int ncons;
    bit acc;
    int cnt;
    model(ok_exp, ncons);
    do_reset();
    got_wr.delete();
    bad_rdy = 0;
    bad_lat = 0;
    for (int i = 0; i < ncons; i++) begin
      send_byte(stim[i], gaps, acc);
      if (!acc) begin
        check({name, ":byte_accept"}, 64'(i), 64'(ncons));
        break;
      end
    end
    vld = 1'b0;
    if (ok_exp) begin
      cnt = 0;
      while (cnt < 64) begin
        @(negedge clk);
        if (done) break;
        cnt++;
      end
      check({name, ":hold_cycles"}, 64'(cnt), 64'(HOLD));
      check({name, ":final_flags"}, {err, cpu_rst, rdy, done}, 4'b0001);
    end else begin
      @(negedge clk);
      check({name, ":final_flags"}, {err, cpu_rst, rdy, done}, 4'b1100);
    end
    check({name, ":n_writes"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check({name, ":write"}, got_wr[i], exp_wr[i]);
    check({name, ":ready_in_write"}, 64'(bad_rdy), 64'd0);
    check({name, ":write_latency"}, 64'(bad_lat), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit acc;
    do_reset();
    check_reset_vals("reset_initial");

    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
    run_load("case1_back_to_back", 1'b0);
    run_load("case1_gaps", 1'b1);

    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2B};
    run_load("bad_checksum", 1'b1);

    stim = '{8'h00, 8'h00, 8'h00};
    run_load("empty_ok", 1'b0);
    stim = '{8'h00, 8'h00, 8'h01};
    run_load("empty_bad", 1'b0);

    stim = '{8'h10, 8'h01};
    run_load("too_many_words", 1'b0);

    // Mid-load reset after two header bytes and six data bytes.
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(stim[i], 1'b0, acc);
    vld = 1'b0;
    do_reset();
    check_reset_vals("reset_mid_load");
    run_load("case1_after_reset", 1'b0);

    for (int t = 0; t < 20; t++) begin
      build($urandom_range(1, 8), $urandom_range(0, 3) != 0);
      run_load("random", 1'b1);
    end

    build(1 << AW, 1'b1);
    run_load("full_image", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
